branch_execute: RTL and testbench
=================================

BRANCH_EXECUTE -- requirements
Module: branch_execute

Interface
REQ-001 SHALL have one clock, clk; reset rst_n is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  async active-low reset.
REQ-004 in_valid  input  1  decoded branch-lane instruction present.
REQ-005 in_ready  output  1  block accepts instruction this cycle.
REQ-006 pc  input  32  address of incoming instruction.
REQ-007 is_nop, is_jmp, is_imm_type, zero_ext  input  1 each  decode flags.
REQ-008 op  input  2  00 EQ, 01 NE (ecall/ebreak when is_jmp), 10 LT, 11 GE.
REQ-009 rd  input  5  link destination.
REQ-010 imm  input  20  decode immediate.
REQ-011 rs1_val, rs2_val  input  32 each  operand values.
REQ-012 out_ready  input  1  writeback/fetch consumer ready.
REQ-013 out_valid  output  1  result register holds a valid result.
REQ-014 redirect  output  1  result is a taken control transfer.
REQ-015 target  output  32  redirect PC.
REQ-016 wb_en, wb_rd, wb_data  output  1/5/32  link writeback.
REQ-017 halted  output  1  ecall/ebreak halt active.
REQ-018 trap_cause  output  1  0 ecall, 1 ebreak.
REQ-019 resume  input  1  one-cycle pulse to leave HALT.
REQ-020 taken_cnt  output  32  saturating count of redirects issued.

Function
REQ-021 Handshake: transfer when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-022 Latency: one cycle; result register loads on transfer, clears out_valid on out_ready without new transfer.
REQ-023 Compare: EQ/NE on equality; LT/GE signed, unsigned when zero_ext.
REQ-024 Conditional branch (!is_jmp, !is_nop): target = pc + (sext(imm)<<1); redirect = compare result; wb_en = 0.
REQ-025 JAL (is_jmp, !is_imm_type, op==00): target = pc + (sext(imm)<<1); redirect = 1; wb_en = (rd!=0); wb_data = pc+4.
REQ-026 JALR (is_jmp, is_imm_type): target = (rs1_val + sext(imm)) & ~1; redirect = 1; wb_en = (rd!=0); wb_data = pc+4.
REQ-027 ecall/ebreak (is_jmp, !is_imm_type, op==01): trap_cause = imm[0]; saved_pc = pc; state -> HALT; redirect = 0, wb_en = 0.
REQ-028 NOP (is_nop): out_valid asserted, redirect = 0, wb_en = 0.
REQ-029 All adds modulo 2^32.
REQ-030 Squash: the transfer in the cycle after a redirect result is handed off (out_valid && out_ready && redirect) SHALL be accepted and discarded (no out_valid, no state change).
REQ-031 States: RUN, HALT. HALT: halted=1, in_ready=0; resume -> RUN with one redirect result to saved_pc+4 (out_valid=1, redirect=1), squash rule applies.
REQ-032 resume while RUN SHALL be ignored.
REQ-033 taken_cnt increments on each handed-off redirect; saturates at 0xFFFF_FFFF.
REQ-034 Result register holds stable while out_valid && !out_ready.

Reset
REQ-035 On rst_n low, immediately: state RUN, out_valid 0, redirect 0, target 0, wb_en 0, wb_rd 0, wb_data 0, halted 0, trap_cause 0, taken_cnt 0, squash flag 0, saved_pc 0.
REQ-036 Reset mid-HALT or mid-stall SHALL discard pending result and trap.

Structure
REQ-037 Shared package holds the op encoding enum, state enum, and result struct (redirect, target, wb_en, wb_rd, wb_data).
REQ-038 One sub-module, branch_compare (combinational: rs1_val, rs2_val, op, zero_ext -> taken).

Verification
REQ-039 BEQ pc=0x100, imm=0x00008, rs1=rs2=5 -> next cycle out_valid, redirect=1, target=0x110, wb_en=0.
REQ-040 BLTU-style zero_ext=1, op=10, rs1=0xFFFFFFFF, rs2=1 -> redirect=0; same with zero_ext=0 -> redirect=1.
REQ-041 JALR rs1=0x2001, imm=0x00002, rd=1, pc=0x40 -> target=0x2002, wb_en=1, wb_rd=1, wb_data=0x44; following accepted instruction squashed.
REQ-042 ecall pc=0x80 -> halted=1, in_ready=0; resume pulse -> redirect to 0x84, halted=0.
REQ-043 out_ready held 0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0; taken_cnt increments exactly once on release.
REQ-044 Assert rst_n low during HALT -> all outputs at REQ-035 values before next clk edge.

Source files
------------

// File: rtl/branch_execute_pkg.sv
// ============================================================================
// branch_execute_pkg : shared types for the branch-lane execute block
// Rev 1.0
// ============================================================================
`default_nettype none

package branch_execute_pkg;

    typedef enum logic [1:0] {
        OP_EQ = 2'b00,
        OP_NE = 2'b01,
        OP_LT = 2'b10,
        OP_GE = 2'b11
    } br_op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } br_state_e;

    typedef struct packed {
        logic        redirect;
        logic [31:0] target;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } br_result_t;

    function automatic logic [31:0] sext_imm(input logic [19:0] imm);
        return {{12{imm[19]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_execute_if.sv
// ============================================================================
// branch_execute_if : instruction, result and halt-control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface branch_execute_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic        is_nop;
    logic        is_jmp;
    logic        is_imm_type;
    logic        zero_ext;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [19:0] imm;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_ready;
    logic        out_valid;
    logic        redirect;
    logic [31:0] target;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        halted;
    logic        trap_cause;
    logic        resume;
    logic [31:0] taken_cnt;

    modport slave (
        input  in_valid, pc, is_nop, is_jmp, is_imm_type, zero_ext, op, rd, imm,
               rs1_val, rs2_val, out_ready, resume,
        output in_ready, out_valid, redirect, target, wb_en, wb_rd, wb_data,
               halted, trap_cause, taken_cnt
    );

    modport master (
        output in_valid, pc, is_nop, is_jmp, is_imm_type, zero_ext, op, rd, imm,
               rs1_val, rs2_val, out_ready, resume,
        input  in_ready, out_valid, redirect, target, wb_en, wb_rd, wb_data,
               halted, trap_cause, taken_cnt
    );
endinterface

`default_nettype wire

// File: rtl/branch_compare.sv
// ============================================================================
// branch_compare : branch condition evaluation (EQ/NE/LT/GE, signed/unsigned)
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_compare
    import branch_execute_pkg::*;
(
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [1:0]  op,
    input  logic        zero_ext,
    output logic        taken
);

    logic w_eq;
    logic w_lt;

    assign w_eq = (rs1_val == rs2_val);
    assign w_lt = zero_ext ? (rs1_val < rs2_val)
                           : ($signed(rs1_val) < $signed(rs2_val));

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(op))
            OP_EQ:   taken = w_eq;
            OP_NE:   taken = !w_eq;
            OP_LT:   taken = w_lt;
            OP_GE:   taken = !w_lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_execute.sv
// ============================================================================
// branch_execute : one-cycle branch/jump execute with link writeback,
//                  wrong-path squash, ecall/ebreak halt and redirect counter
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_execute
    import branch_execute_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    branch_execute_if.slave  bus
);

    br_state_e   r_state, w_state_next;
    br_result_t  r_result, w_result_next;
    logic        r_out_valid, w_out_valid_next;
    logic        r_trap_cause, w_trap_cause_next;
    logic [31:0] r_saved_pc, w_saved_pc_next;
    logic        r_squash;
    logic [31:0] r_taken_cnt;

    logic        w_taken;
    logic        w_slot_free;
    logic        w_fire;
    logic        w_handoff_redirect;
    logic [31:0] w_imm_sext;
    logic [31:0] w_pc_rel_target;
    logic [31:0] w_link;

    branch_compare u_compare (
        .rs1_val  (bus.rs1_val),
        .rs2_val  (bus.rs2_val),
        .op       (bus.op),
        .zero_ext (bus.zero_ext),
        .taken    (w_taken)
    );

    assign w_slot_free        = !r_out_valid || bus.out_ready;
    assign bus.in_ready       = (r_state == ST_RUN) && w_slot_free;
    assign w_fire             = bus.in_valid && bus.in_ready;
    assign w_handoff_redirect = r_out_valid && bus.out_ready && r_result.redirect;
    assign w_imm_sext         = sext_imm(bus.imm);
    assign w_pc_rel_target    = bus.pc + (w_imm_sext << 1);
    assign w_link             = bus.pc + 32'd4;

    always_comb begin
        w_state_next      = r_state;
        w_result_next     = r_result;
        w_out_valid_next  = r_out_valid;
        w_trap_cause_next = r_trap_cause;
        w_saved_pc_next   = r_saved_pc;

        if (r_out_valid && bus.out_ready) begin
            w_out_valid_next = 1'b0;
        end

        case (r_state)
            ST_RUN: begin
                // A squashed transfer is consumed but leaves no trace
                if (w_fire && !r_squash) begin
                    w_out_valid_next = 1'b1;
                    w_result_next    = '0;
                    if (bus.is_nop) begin
                        w_result_next = '0;
                    end else if (!bus.is_jmp) begin
                        w_result_next.redirect = w_taken;
                        w_result_next.target   = w_pc_rel_target;
                    end else if (bus.is_imm_type) begin
                        w_result_next.redirect = 1'b1;
                        w_result_next.target   = (bus.rs1_val + w_imm_sext) & ~32'd1;
                        w_result_next.wb_en    = (bus.rd != 5'd0);
                        w_result_next.wb_rd    = bus.rd;
                        w_result_next.wb_data  = w_link;
                    end else if (br_op_e'(bus.op) == OP_NE) begin
                        w_trap_cause_next = bus.imm[0];
                        w_saved_pc_next   = bus.pc;
                        w_state_next      = ST_HALT;
                    end else begin
                        w_result_next.redirect = 1'b1;
                        w_result_next.target   = w_pc_rel_target;
                        w_result_next.wb_en    = (bus.rd != 5'd0);
                        w_result_next.wb_rd    = bus.rd;
                        w_result_next.wb_data  = w_link;
                    end
                end
            end
            ST_HALT: begin
                // Resume waits for the trap result to drain so the register stays stable
                if (bus.resume && w_slot_free) begin
                    w_state_next           = ST_RUN;
                    w_out_valid_next       = 1'b1;
                    w_result_next          = '0;
                    w_result_next.redirect = 1'b1;
                    w_result_next.target   = r_saved_pc + 32'd4;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_result     <= '0;
            r_out_valid  <= 1'b0;
            r_trap_cause <= 1'b0;
            r_saved_pc   <= '0;
            r_squash     <= 1'b0;
            r_taken_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_result     <= w_result_next;
            r_out_valid  <= w_out_valid_next;
            r_trap_cause <= w_trap_cause_next;
            r_saved_pc   <= w_saved_pc_next;
            r_squash     <= w_handoff_redirect;
            if (w_handoff_redirect && (r_taken_cnt != 32'hFFFF_FFFF)) begin
                r_taken_cnt <= r_taken_cnt + 32'd1;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.redirect   = r_result.redirect;
    assign bus.target     = r_result.target;
    assign bus.wb_en      = r_result.wb_en;
    assign bus.wb_rd      = r_result.wb_rd;
    assign bus.wb_data    = r_result.wb_data;
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.trap_cause = r_trap_cause;
    assign bus.taken_cnt  = r_taken_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_execute.sv
// ============================================================================
// tb_branch_execute : directed self-checking bench for branch_execute
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_execute;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    branch_execute_if bus ();

    branch_execute u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic nop, input logic jmp, input logic immt, input logic zext,
                         input logic [1:0] op, input logic [4:0] rd, input logic [19:0] imm,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid    = 1'b1;
        bus.is_nop      = nop;
        bus.is_jmp      = jmp;
        bus.is_imm_type = immt;
        bus.zero_ext    = zext;
        bus.op          = op;
        bus.rd          = rd;
        bus.imm         = imm;
        bus.pc          = pc;
        bus.rs1_val     = rs1;
        bus.rs2_val     = rs2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.out_ready = 1'b1;
        bus.resume    = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 5'd0, 20'd0, 32'd0, 32'd0, 32'd0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_taken_cnt", bus.taken_cnt, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        // BEQ taken
        drive(0, 0, 0, 0, 2'b00, 5'd3, 20'h00008, 32'h100, 32'd5, 32'd5);
        tick();
        bus.in_valid = 1'b0;
        check("beq_valid", bus.out_valid, 1);
        check("beq_redirect", bus.redirect, 1);
        check("beq_target", bus.target, 32'h110);
        check("beq_wb_en", bus.wb_en, 0);
        tick();
        check("beq_handoff_valid", bus.out_valid, 0);
        check("beq_cnt", bus.taken_cnt, 1);
        tick();

        // Unsigned then signed LT on the same operands, back to back
        drive(0, 0, 0, 1, 2'b10, 5'd0, 20'h00004, 32'h200, 32'hFFFF_FFFF, 32'd1);
        tick();
        check("bltu_valid", bus.out_valid, 1);
        check("bltu_redirect", bus.redirect, 0);
        drive(0, 0, 0, 0, 2'b10, 5'd0, 20'h00004, 32'h200, 32'hFFFF_FFFF, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("blt_redirect", bus.redirect, 1);
        check("blt_target", bus.target, 32'h208);
        tick();
        check("blt_cnt", bus.taken_cnt, 2);
        tick();

        // BNE equal operands, BGE signed -2 >= 3 false
        drive(0, 0, 0, 0, 2'b01, 5'd0, 20'h00010, 32'h240, 32'd5, 32'd5);
        tick();
        check("bne_redirect", bus.redirect, 0);
        drive(0, 0, 0, 0, 2'b11, 5'd0, 20'h00010, 32'h240, 32'hFFFF_FFFE, 32'd3);
        tick();
        bus.in_valid = 1'b0;
        check("bge_valid", bus.out_valid, 1);
        check("bge_redirect", bus.redirect, 0);
        tick();
        check("bge_cnt", bus.taken_cnt, 2);

        // JALR then the following accepted instruction is squashed
        drive(0, 1, 1, 0, 2'b00, 5'd1, 20'h00002, 32'h40, 32'h2001, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("jalr_redirect", bus.redirect, 1);
        check("jalr_target", bus.target, 32'h2002);
        check("jalr_wb_en", bus.wb_en, 1);
        check("jalr_wb_rd", bus.wb_rd, 1);
        check("jalr_wb_data", bus.wb_data, 32'h44);
        tick();
        check("jalr_cnt", bus.taken_cnt, 3);
        check("squash_in_ready", bus.in_ready, 1);
        drive(0, 0, 0, 0, 2'b00, 5'd0, 20'h00008, 32'h300, 32'd7, 32'd7);
        tick();
        bus.in_valid = 1'b0;
        check("squash_valid", bus.out_valid, 0);
        tick();
        check("squash_cnt", bus.taken_cnt, 3);

        // JAL rd=0 with negative offset
        drive(0, 1, 0, 0, 2'b00, 5'd0, 20'hFFFFE, 32'h500, 32'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("jal_redirect", bus.redirect, 1);
        check("jal_target", bus.target, 32'h4FC);
        check("jal_wb_en", bus.wb_en, 0);
        tick();
        tick();

        // Back-pressure: result holds for 3 cycles, counted once on release
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 2'b00, 5'd0, 20'h00010, 32'h600, 32'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_target", bus.target, 32'h620);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_cnt", bus.taken_cnt, 4);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_release_cnt", bus.taken_cnt, 5);
        check("stall_release_valid", bus.out_valid, 0);
        tick();

        // NOP
        drive(1, 0, 0, 0, 2'b00, 5'd7, 20'h00010, 32'h700, 32'd1, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("nop_valid", bus.out_valid, 1);
        check("nop_redirect", bus.redirect, 0);
        check("nop_wb_en", bus.wb_en, 0);
        tick();

        // resume in RUN is ignored
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume_run_valid", bus.out_valid, 0);
        check("resume_run_halted", bus.halted, 0);

        // ecall, halt, resume
        drive(0, 1, 0, 0, 2'b01, 5'd0, 20'h00000, 32'h80, 32'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("ecall_halted", bus.halted, 1);
        check("ecall_in_ready", bus.in_ready, 0);
        check("ecall_redirect", bus.redirect, 0);
        check("ecall_cause", bus.trap_cause, 0);
        tick();
        check("halt_hold", bus.halted, 1);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume_halted", bus.halted, 0);
        check("resume_valid", bus.out_valid, 1);
        check("resume_redirect", bus.redirect, 1);
        check("resume_target", bus.target, 32'h84);
        tick();
        check("resume_cnt", bus.taken_cnt, 6);
        tick();

        // ebreak, then asynchronous reset while halted
        drive(0, 1, 0, 0, 2'b01, 5'd0, 20'h00001, 32'h90, 32'd0, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("ebreak_halted", bus.halted, 1);
        check("ebreak_cause", bus.trap_cause, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_halted", bus.halted, 0);
        check("arst_cause", bus.trap_cause, 0);
        check("arst_valid", bus.out_valid, 0);
        check("arst_cnt", bus.taken_cnt, 0);
        check("arst_target", bus.target, 0);
        check("arst_wb_data", bus.wb_data, 0);
        check("arst_in_ready", bus.in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
